// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, PC alias index helper and data word type for reg_file_rd_mux.
package reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF = 16;
    localparam int PC_IDX = DEPTH_DEF - 1;
    typedef logic [DATA_W_DEF-1:0] data_t;
    function automatic int pc_idx(input int depth);
        return depth - 1;
    endfunction
endpackage

// File: rtl/reg_file_rd_mux_mux_n1.sv
// mux_n1: DATA_W-wide DEPTH:1 combinational selector over a flattened input vector.
module mux_n1 #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH*DATA_W-1:0] din,
    input  logic [ADDR_W-1:0]       sel,
    output logic [DATA_W-1:0]       dout
);
    assign dout = din[sel*DATA_W +: DATA_W];
endmodule

// File: rtl/reg_file_rd_mux.sv
// reg_file_rd_mux: register file, NUM_RD combinational read ports, one write port, top entry aliased to pc_alias.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_rd_mux
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic [DATA_W-1:0]        pc_alias,
    output logic                     wr_ignored
);
    localparam logic [ADDR_W-1:0] PC = ADDR_W'(pc_idx(DEPTH));

    logic [DEPTH-2:0][DATA_W-1:0] mem_q, mem_d;
    logic                         wr_ignored_q, wr_ignored_d;
    logic [NUM_RD*DATA_W-1:0]     mux_out;

    // Only stored entries are updated, so a write to PC naturally falls through.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++)
            mem_d[i] = (we && wa == ADDR_W'(i)) ? wd : mem_q[i];
        wr_ignored_d = we && wa == PC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q        <= '0;
            wr_ignored_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ignored_q <= wr_ignored_d;
        end
    end

    assign wr_ignored = wr_ignored_q;

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] a;
            assign a = ra[k*ADDR_W +: ADDR_W];
            mux_n1 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mux (
                .din ({{DATA_W{1'b0}}, mem_q}),
                .sel (a),
                .dout(mux_out[k*DATA_W +: DATA_W])
            );
`ifdef REG_FILE_BYPASS_EN
            assign rd[k*DATA_W +: DATA_W] = (a == PC) ? pc_alias :
                                            (!reset && we && wa == a) ? wd :
                                            mux_out[k*DATA_W +: DATA_W];
`else
            assign rd[k*DATA_W +: DATA_W] = (a == PC) ? pc_alias : mux_out[k*DATA_W +: DATA_W];
`endif
        end
    endgenerate
endmodule
